// File: rtl/regfile_param.sv
// Parametrised two-read / one-write register file.
// Registered reads with optional write-to-read bypass, optional hardwired-zero
// entry 0, and a sequenced bulk-clear engine that wipes the array one entry
// per cycle without needing a reset.
//
// Clear handshake: clr_req is a level sampled only in IDLE. clr_busy is high
// for the DEPTH cycles of the wipe. clr_done pulses for one cycle afterwards.
// Writes presented while clr_busy or clr_done is high are dropped, so the
// writer must stall on them.
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              idle;
  logic              wr_en;

  assign idle  = (state_q == ST_IDLE);
  // Writes only land in IDLE. Address 0 is read-only when it is the zero register.
  assign wr_en = RegWrite && idle && !(ZERO_EN && (WriteAddr == '0));

  // Read mux: zero register first, then same-cycle bypass, then array contents.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (ZERO_EN && (addr == '0)) begin
      read_port = '0;
    end else if (BYP_EN && RegWrite && idle && (WriteAddr == addr)) begin
      read_port = WriteData;
    end else begin
      read_port = mem_q[addr];
    end
  endfunction

  // Clear sequencer next-state: IDLE -> CLEAR (DEPTH cycles) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Array next-state: the clear pointer has priority, otherwise the write port.
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[ptr_q] = '0;
    end else if (wr_en) begin
      mem_d[WriteAddr] = WriteData;
    end
  end

  // Read data for both ports, captured at the next edge.
  always_comb begin
    rd1_d = read_port(ReadAddr1);
    rd2_d = read_port(ReadAddr2);
  end

  // State, pointer, array and read registers; reset wipes everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ReadData1 = rd1_q;
  assign ReadData2 = rd2_q;
  assign clr_busy  = (state_q == ST_CLEAR);
  assign clr_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three 16-bit variants (default, no bypass, zero
// register) share one stimulus stream, plus a 32-bit / 16-entry variant.
// Drivers push hand-computed expectations. A monitor pops them after each edge.
module tb_regfile_param;

  logic clk;
  logic rst;

  // Shared stimulus for the 16-bit variants.
  logic        we;
  logic [2:0]  wa;
  logic [15:0] wd;
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic        creq;

  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2, z_rd1, z_rd2;
  logic        a_busy, a_done, b_busy, b_done, z_busy, z_done;

  // Wide variant stimulus and outputs.
  logic        w_we;
  logic [3:0]  w_wa;
  logic [31:0] w_wd;
  logic [3:0]  w_ra1;
  logic [3:0]  w_ra2;
  logic        w_creq;
  logic [31:0] w_rd1, w_rd2;
  logic        w_busy, w_done;

  // Expected entries: {care_rd, busy, done, rd1, rd2}.
  logic [34:0] exp_a_q[$];
  logic [34:0] exp_b_q[$];
  logic [34:0] exp_z_q[$];
  logic [66:0] exp_w_q[$];

  int checks = 0;
  int errors = 0;

  regfile_param u_a (
    .clk(clk), .rst(rst), .RegWrite(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr1(ra1), .ReadAddr2(ra2), .ReadData1(a_rd1), .ReadData2(a_rd2),
    .clr_req(creq), .clr_busy(a_busy), .clr_done(a_done)
  );

  regfile_param #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .RegWrite(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr1(ra1), .ReadAddr2(ra2), .ReadData1(b_rd1), .ReadData2(b_rd2),
    .clr_req(creq), .clr_busy(b_busy), .clr_done(b_done)
  );

  regfile_param #(.ZERO_REG(1)) u_z (
    .clk(clk), .rst(rst), .RegWrite(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr1(ra1), .ReadAddr2(ra2), .ReadData1(z_rd1), .ReadData2(z_rd2),
    .clr_req(creq), .clr_busy(z_busy), .clr_done(z_done)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(4)) u_w (
    .clk(clk), .rst(rst), .RegWrite(w_we), .WriteAddr(w_wa), .WriteData(w_wd),
    .ReadAddr1(w_ra1), .ReadAddr2(w_ra2), .ReadData1(w_rd1), .ReadData2(w_rd2),
    .clr_req(w_creq), .clr_busy(w_busy), .clr_done(w_done)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after it.
  always @(posedge clk) begin : monitor
    logic [34:0] e;
    logic [66:0] ew;
    #1;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      check("a_clr", {78'd0, a_busy, a_done}, {78'd0, e[33], e[32]});
      if (e[34]) begin
        check("a_rd1", {64'd0, a_rd1}, {64'd0, e[31:16]});
        check("a_rd2", {64'd0, a_rd2}, {64'd0, e[15:0]});
      end
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      check("b_clr", {78'd0, b_busy, b_done}, {78'd0, e[33], e[32]});
      if (e[34]) begin
        check("b_rd1", {64'd0, b_rd1}, {64'd0, e[31:16]});
        check("b_rd2", {64'd0, b_rd2}, {64'd0, e[15:0]});
      end
    end
    if (exp_z_q.size() > 0) begin
      e = exp_z_q.pop_front();
      check("z_clr", {78'd0, z_busy, z_done}, {78'd0, e[33], e[32]});
      if (e[34]) begin
        check("z_rd1", {64'd0, z_rd1}, {64'd0, e[31:16]});
        check("z_rd2", {64'd0, z_rd2}, {64'd0, e[15:0]});
      end
    end
    if (exp_w_q.size() > 0) begin
      ew = exp_w_q.pop_front();
      check("w_clr", {78'd0, w_busy, w_done}, {78'd0, ew[65], ew[64]});
      if (ew[66]) begin
        check("w_rd", {16'd0, w_rd1, w_rd2}, {16'd0, ew[63:0]});
      end
    end
  end

  // Driver for the 16-bit variants: drive one cycle and queue the outputs
  // expected after the coming edge.
  task automatic step(input logic s_we, input logic [2:0] s_wa, input logic [15:0] s_wd,
                      input logic [2:0] s_ra1, input logic [2:0] s_ra2, input logic s_creq,
                      input logic care, input logic busy, input logic done,
                      input logic [15:0] a1, input logic [15:0] a2,
                      input logic [15:0] b1, input logic [15:0] b2,
                      input logic [15:0] z1, input logic [15:0] z2);
    @(negedge clk);
    we   = s_we;
    wa   = s_wa;
    wd   = s_wd;
    ra1  = s_ra1;
    ra2  = s_ra2;
    creq = s_creq;
    exp_a_q.push_back({care, busy, done, a1, a2});
    exp_b_q.push_back({care, busy, done, b1, b2});
    exp_z_q.push_back({care, busy, done, z1, z2});
  endtask

  task automatic wstep(input logic s_we, input logic [3:0] s_wa, input logic [31:0] s_wd,
                       input logic [3:0] s_ra1, input logic [3:0] s_ra2,
                       input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    w_we  = s_we;
    w_wa  = s_wa;
    w_wd  = s_wd;
    w_ra1 = s_ra1;
    w_ra2 = s_ra2;
    exp_w_q.push_back({1'b1, 1'b0, 1'b0, r1, r2});
  endtask

  initial begin
    logic [15:0] r1;
    rst = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; creq = 1'b0;
    w_we = 1'b0; w_wa = '0; w_wd = '0; w_ra1 = '0; w_ra2 = '0; w_creq = 1'b0;

    // Reset is asynchronous: outputs are zero before any clock edge.
    #2;
    check("reset_a", {46'd0, a_busy, a_done, a_rd1, a_rd2}, 80'd0);
    check("reset_b", {46'd0, b_busy, b_done, b_rd1, b_rd2}, 80'd0);
    check("reset_z", {46'd0, z_busy, z_done, z_rd1, z_rd2}, 80'd0);
    check("reset_w", {14'd0, w_busy, w_done, w_rd1, w_rd2}, 80'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Write then read.
    step(1, 3'd5, 16'hBEEF, 3'd0, 3'd0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(0, 3'd0, 16'h0, 3'd5, 3'd5, 0, 1, 0, 0,
         16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);

    // Bypass on both ports at once.
    step(1, 3'd3, 16'h1111, 3'd0, 3'd0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(1, 3'd3, 16'h2222, 3'd3, 3'd3, 0, 1, 0, 0,
         16'h2222, 16'h2222, 16'h1111, 16'h1111, 16'h2222, 16'h2222);
    step(0, 3'd0, 16'h0, 3'd3, 3'd3, 0, 1, 0, 0,
         16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h2222);

    // Address 0: writable normally, hardwired zero in the zero-register variant.
    step(1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 0, 1, 0, 0,
         16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0);
    step(0, 3'd0, 16'h0, 3'd0, 3'd5, 0, 1, 0, 0,
         16'hFFFF, 16'hBEEF, 16'hFFFF, 16'hBEEF, 16'h0, 16'hBEEF);

    // Fill every entry with A000+i.
    for (int i = 0; i < 8; i++) begin
      step(1, 3'(i), 16'hA000 + 16'(i), 3'(i), 3'(i), 0, 0, 0, 0,
           16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    end
    step(0, 3'd0, 16'h0, 3'd6, 3'd0, 0, 1, 0, 0,
         16'hA006, 16'hA000, 16'hA006, 16'hA000, 16'hA006, 16'h0);

    // Start a clear. busy is seen after 8 edges, then done for one.
    step(0, 3'd0, 16'h0, 3'd1, 3'd2, 1, 1, 1, 0,
         16'hA001, 16'hA002, 16'hA001, 16'hA002, 16'hA001, 16'hA002);
    for (int c = 1; c <= 8; c++) begin
      // Entry 2 is wiped at edge 3; the write to it at edge 5 must be lost.
      r1 = (c <= 3) ? 16'hA002 : 16'h0;
      step(c == 5, 3'd2, 16'h5555, 3'd2, 3'd7, 0, 1, c <= 7, c == 8,
           r1, 16'hA007, r1, 16'hA007, r1, 16'hA007);
    end
    // In DONE: write and clr_req are both ignored.
    step(1, 3'd4, 16'h5555, 3'd2, 3'd7, 1, 1, 0, 0,
         16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(0, 3'd0, 16'h0, 3'd4, 3'd7, 0, 1, 0, 0,
         16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      step(0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 0, 1, 0, 0,
           16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    end

    // Reset in the middle of a clear: entry 6 is not yet wiped by the sequence.
    step(1, 3'd6, 16'h1234, 3'd0, 3'd0, 0, 0, 0, 0,
         16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(0, 3'd0, 16'h0, 3'd6, 3'd6, 1, 1, 1, 0,
         16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    for (int c = 1; c <= 3; c++) begin
      step(0, 3'd0, 16'h0, 3'd6, 3'd6, 0, 0, 1, 0,
           16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    end
    @(negedge clk);
    creq = 1'b0;
    rst  = 1'b0;
    #1;
    check("midclr_a", {46'd0, a_busy, a_done, a_rd1, a_rd2}, 80'd0);
    check("midclr_z", {46'd0, z_busy, z_done, z_rd1, z_rd2}, 80'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 3'd0, 16'h0, 3'(i), 3'(i), 0, 1, 0, 0,
           16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    end

    // Wide variant: 32-bit data, 16 entries.
    step(0, 3'd0, 16'h0, 3'd0, 3'd0, 0, 0, 0, 0,
         16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    wstep(1, 4'd15, 32'hDEADBEEF, 4'd15, 4'd0, 32'hDEADBEEF, 32'h0);
    wstep(0, 4'd0, 32'h0, 4'd15, 4'd14, 32'hDEADBEEF, 32'h0);
    wstep(1, 4'd8, 32'h12345678, 4'd8, 4'd15, 32'h12345678, 32'hDEADBEEF);
    wstep(0, 4'd0, 32'h0, 4'd7, 4'd8, 32'h0, 32'h12345678);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drain",
          80'(exp_a_q.size() + exp_b_q.size() + exp_z_q.size() + exp_w_q.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 8x16 two-read/one-write register file in the datapath.
- Generalised in data width and depth, with:
  - optional hardwired-zero entry 0
  - selectable write-to-read bypass
  - sequenced bulk-clear engine that wipes the array without a reset
- Sits between the decode/operand-fetch stage (rs/rt reads) and writeback.

Parameters:
- DATA_W, 16, width of each entry and of the data ports.
- ADDR_W, 3, address width; depth is fixed at DEPTH = 2**ADDR_W (8 by default).
- ZERO_REG, 0, if 1, entry 0 always reads 0 and writes to address 0 are discarded.
- BYPASS, 1, if 1, a read of the address being written in the same cycle returns the new data; if 0, it returns the old contents.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- RegWrite  in  1  write enable.
- WriteAddr  in  ADDR_W  write address.
- WriteData  in  DATA_W  write data.
- ReadAddr1  in  ADDR_W  read port 1 address (rs).
- ReadAddr2  in  ADDR_W  read port 2 address (rt).
- ReadData1  out  DATA_W  registered read data, port 1.
- ReadData2  out  DATA_W  registered read data, port 2.
- clr_req  in  1  bulk-clear request, sampled in IDLE only.
- clr_busy  out  1  high while the clear sequence runs.
- clr_done  out  1  one-cycle pulse when the clear sequence completes.

Behaviour:
- Reset (rst low, asynchronous):
  - all DEPTH entries = 0
  - ReadData1/2 = 0
  - clr_busy = 0, clr_done = 0
  - FSM = IDLE, clear pointer = 0
  - Reset mid-clear aborts the sequence immediately.
- Reads:
  - Synchronous with 1-cycle latency: ReadDataN at edge k+1 reflects ReadAddrN sampled at edge k.
  - Reads occur every cycle regardless of RegWrite.
  - No out-of-range case exists (DEPTH = 2**ADDR_W).
- Writes:
  - On a rising edge with RegWrite=1 and FSM=IDLE, entry[WriteAddr] <= WriteData.
  - With ZERO_REG=1 and WriteAddr=0, the write is dropped.
- Bypass (same edge, RegWrite=1, WriteAddr==ReadAddrN, FSM=IDLE):
  - BYPASS=1: ReadDataN <= WriteData.
  - BYPASS=0: ReadDataN <= old entry value.
  - With ZERO_REG=1 and address 0, ReadDataN <= 0 in either case.
  - Both ports may bypass simultaneously.
- Zero register: with ZERO_REG=1, a read of address 0 returns 0 always.
- Clear FSM states:
  - IDLE: clr_busy=0. If clr_req=1 at an edge, go to CLEAR with ptr=0. A RegWrite in that same cycle still commits, and is then overwritten by the clear.
  - CLEAR: clr_busy=1. Each edge writes entry[ptr] <= 0 and increments ptr. When ptr==DEPTH-1, go to DONE. Takes exactly DEPTH cycles.
  - DONE: clr_done=1 for exactly one cycle, clr_busy=0, then return to IDLE.
- Behaviour during CLEAR and DONE:
  - RegWrite is ignored and the write is lost; the upstream stage must stall on clr_busy.
  - clr_req is ignored.
  - Reads continue normally with no bypass, returning current array contents, which may be partially cleared.
- Timing: clr_req held high across DONE starts a new clear from IDLE on the next edge. Minimum gap between clear starts is DEPTH+2 cycles.

Test Plan:
- Reset with defaults: assert rst low mid-cycle -> all outputs 0 immediately, with no clock edge needed.
- Write then read: write 16'hBEEF to addr 5; next cycle ReadAddr1=5 -> ReadData1=16'hBEEF one edge later.
- Bypass:
  - BYPASS=1: addr 3 holds 16'h1111; same edge write 16'h2222 to addr 3 with ReadAddr1=ReadAddr2=3 -> both outputs 16'h2222.
  - BYPASS=0: same stimulus -> both outputs 16'h1111.
- Zero register (ZERO_REG=1): write 16'hFFFF to addr 0, then read addr 0 -> 0, including the same-cycle bypass case.
- Bulk clear:
  - Fill entries 0-7 with 16'hA000+i, pulse clr_req -> clr_busy high for exactly 8 cycles, then clr_done high for 1 cycle.
  - A RegWrite of 16'h5555 to addr 2 during CLEAR is lost.
  - All entries read 0 afterwards.
- Reset mid-clear and generic width: assert rst low at clear cycle 4 -> clr_busy=0 at once and the array is all zero. Then run DATA_W=32, ADDR_W=4: write 32'hDEADBEEF to addr 15 -> reads back correctly.
